sort5_seq_ctrl: RTL and testbench

- Sequential controller that owns one bubble-pass compare-exchange chain over N registered words.
- Collects N words over a valid/ready input stream, then applies N-1 bubble passes, one pass per clock.
- Streams the words out in ascending order over a valid/ready output stream.
- Wraps the sorter datapath so the upstream and downstream blocks see a simple word-serial interface.

---
 rtl/sort5_seq_ctrl.sv | 152 +++++++++++++++
 tb/tb_sort5_seq_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/sort5_seq_ctrl.sv
// Word-serial sorting controller: loads N words, runs N-1 bubble passes
// (one per clock), then streams the words out in ascending order.
module sort5_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int N     = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  input  logic             abort,
  output logic             busy
);

  localparam int IW = $clog2(N) + 1;
  localparam int AW = $clog2(N);

  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] r_q [N];
  logic [WIDTH-1:0] r_d [N];
  logic [WIDTH-1:0] pass_r [N];
  logic [IW-1:0]    idx_q, idx_d, idx_nxt;
  logic [IW-1:0]    pcnt_q, pcnt_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  // One compare-exchange chain: the carried value c bubbles the maximum upward.
  always_comb begin
    logic [WIDTH-1:0] c;
    pass_r = r_q;
    c      = r_q[0];
    for (int unsigned i = 1; i < N; i++) begin
      if (c > r_q[i]) begin
        pass_r[i-1] = r_q[i];
      end else begin
        pass_r[i-1] = c;
        c           = r_q[i];
      end
    end
    pass_r[N-1] = c;
  end

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    idx_d       = idx_q;
    pcnt_d      = pcnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    out_data_d  = out_data_q;
    idx_nxt     = idx_q + IW'(1);

    if (abort) begin
      state_d     = LOAD;
      idx_d       = '0;
      pcnt_d      = '0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      busy_d      = 1'b0;
      in_ready_d  = 1'b1;
    end else begin
      unique case (state_q)
        LOAD: begin
          in_ready_d = 1'b1;
          if (in_valid && in_ready_q) begin
            r_d[idx_q[AW-1:0]] = in_data;
            idx_d              = idx_nxt;
            if (idx_q == IW'(N - 1)) begin
              in_ready_d = 1'b0;
              idx_d      = '0;
              pcnt_d     = '0;
              busy_d     = 1'b1;
              state_d    = SORT;
            end
          end
        end
        SORT: begin
          r_d    = pass_r;
          pcnt_d = pcnt_q + IW'(1);
          if (pcnt_q == IW'(N - 2)) begin
            state_d     = DRAIN;
            idx_d       = '0;
            out_valid_d = 1'b1;
            out_last_d  = 1'b0;
            out_data_d  = pass_r[0];
          end
        end
        DRAIN: begin
          if (out_valid_q && out_ready) begin
            if (out_last_q) begin
              state_d     = LOAD;
              idx_d       = '0;
              out_valid_d = 1'b0;
              out_last_d  = 1'b0;
              busy_d      = 1'b0;
              in_ready_d  = 1'b1;
            end else begin
              // Present the next element right away so the stream has no bubble.
              idx_d      = idx_nxt;
              out_data_d = r_q[idx_nxt[AW-1:0]];
              out_last_d = (idx_nxt == IW'(N - 1));
            end
          end
        end
        default: state_d = LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      r_q         <= '{default: '0};
      idx_q       <= '0;
      pcnt_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      idx_q       <= idx_d;
      pcnt_q      <= pcnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      out_data_q  <= out_data_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_sort5_seq_ctrl.sv
// Self-checking bench for sort5_seq_ctrl: directed jobs plus randomized jobs
// checked against an insertion-sort reference model.
module tb_sort5_seq_ctrl;

  localparam int W = 8;
  localparam int N = 5;

  typedef logic [W-1:0] q8_t [$];

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         out_last;
  logic         abort = 1'b0;
  logic         busy;

  int errors = 0;
  int checks = 0;
  int unsigned cyc = 0;
  int unsigned acc_cyc = 0;

  sort5_seq_ctrl #(.WIDTH(W), .N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .abort(abort), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: ascending order built by ordered insertion.
  function automatic q8_t model_sort(input q8_t v);
    q8_t s;
    s = {};
    foreach (v[i]) begin
      int unsigned pos = 0;
      while (pos < s.size() && s[pos] <= v[i]) pos++;
      s.insert(pos, v[i]);
    end
    return s;
  endfunction

  task automatic send(input q8_t vals, input bit rnd);
    int unsigned k = 0;
    int unsigned budget = 0;
    while (k < vals.size()) begin
      @(negedge clk);
      in_valid = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      in_data  = in_valid ? vals[k] : W'($urandom);
      if (in_valid && in_ready) begin
        k++;
        acc_cyc = cyc + 1;
      end
      if (++budget > 200) begin
        check("send_timeout", 0, 1);
        break;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic recv(input q8_t exp, input int stall_at, input int stall_len,
                      input int abort_at, input bit rnd);
    int unsigned k = 0;
    int unsigned budget = 0;
    int stalled = 0;
    bit first = 1'b1;
    bit hold = 1'b0;
    logic [W-1:0] held = '0;
    while (k < exp.size()) begin
      if (k != 0 || !first) ; // waiting continues below
      @(negedge clk);
      if (++budget > 300) begin
        check("recv_timeout", 0, 1);
        return;
      end
      if (abort_at >= 0 && int'(k) == abort_at) begin
        abort = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1 abort = 1'b0;
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 1);
        return;
      end
      if (out_valid) begin
        if (first) begin
          first = 1'b0;
          check("latency", cyc - acc_cyc, N - 1);
        end
        if (hold) check("stall_stable", out_data, held);
        check($sformatf("data%0d", k), out_data, exp[k]);
        check($sformatf("last%0d", k), out_last, (k == exp.size() - 1));
        if (int'(k) == stall_at && stalled < stall_len) begin
          out_ready = 1'b0;
          stalled++;
        end else begin
          out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        hold = !out_ready;
        held = out_data;
        if (out_ready) k++;
      end else begin
        if (first) begin
          check("sort_busy", busy, 1);
          check("sort_in_ready", in_ready, 0);
        end
        out_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
    check("done_in_ready", in_ready, 1);
    check("done_out_valid", out_valid, 0);
    check("done_busy", busy, 0);
  endtask

  task automatic job(input q8_t v, input bit rnd, input int stall_at, input int stall_len);
    send(v, rnd);
    recv(model_sort(v), stall_at, stall_len, -1, rnd);
  endtask

  initial begin
    q8_t v;
    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 check("release_in_ready", in_ready, 1);

    v = '{9, 3, 7, 1, 5};       job(v, 1'b0, -1, 0);
    v = '{255, 0, 128, 0, 255}; job(v, 1'b0, -1, 0);
    v = '{1, 2, 3, 4, 5};       job(v, 1'b0, -1, 0);
    v = '{5, 4, 3, 2, 1};       job(v, 1'b0, -1, 0);
    v = '{40, 10, 30, 20, 50};  job(v, 1'b1, 2, 3);

    // Abort during LOAD; the word offered with abort must be discarded.
    v = '{77, 88, 99};
    send(v, 1'b0);
    @(negedge clk);
    abort = 1'b1; in_valid = 1'b1; in_data = 8'd200;
    @(posedge clk);
    #1 abort = 1'b0; in_valid = 1'b0;
    check("abort_load_in_ready", in_ready, 1);
    check("abort_load_busy", busy, 0);
    v = '{6, 2, 8, 4, 0};       job(v, 1'b0, -1, 0);

    // Abort during DRAIN after two outputs.
    v = '{6, 2, 8, 4, 0};
    send(v, 1'b0);
    recv(model_sort(v), -1, 0, 2, 1'b0);
    v = '{3, 1, 4, 1, 5};       job(v, 1'b0, -1, 0);

    // Asynchronous reset between edges while sorting.
    v = '{50, 40, 30, 20, 10};
    send(v, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_in_ready", in_ready, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_out_last", out_last, 0);
    check("arst_busy", busy, 0);
    check("arst_out_data", out_data, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 check("arst_release_in_ready", in_ready, 1);
    check("arst_release_out_valid", out_valid, 0);

    for (int j = 0; j < 8; j++) begin
      v = {};
      for (int i = 0; i < N; i++) v.push_back(W'($urandom_range(0, (j < 4) ? 255 : 7)));
      job(v, 1'b1, int'($urandom_range(0, N - 1)), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
